// File: rtl/fast_control_monitor.sv
// ---------------------------------------------------------------------------
// fast_control_monitor
//
// Front-end receiver for the ngCCM fast-control lines (QIE reset and WTE),
// clocked by the recovered LHC clock. It locks to the orbit by measuring the
// QIE-reset period, reports the bunch-crossing position, orbit and WTE counts
// and the WTE phase within the orbit. It also counts period errors and WTE
// phase errors so the emulator's fast-control output can be validated.
//
// Ports:
//   clk_in          in   fast-control clock
//   reset_in        in   asynchronous active-high reset
//   qie_reset_in    in   QIE reset line, active high, synchronous to clk_in
//   wte_in          in   WTE line, active high, synchronous to clk_in
//   clear_in        in   synchronous clear of the statistics counters
//   locked          out  high while the FSM is in the locked state
//   bx_count        out  clocks since the last QIE-reset edge (saturating)
//   orbit_count     out  good orbits seen while locked (wraps)
//   wte_count       out  WTE rising edges seen (wraps)
//   wte_phase       out  bx_count captured at the last WTE edge
//   orbit_err_count out  period / missing-reset errors (saturates at 255)
//   wte_err_count   out  WTE phase errors while locked (saturates at 255)
// ---------------------------------------------------------------------------
module fast_control_monitor #(
    parameter int ORBIT_LEN  = 3564,
    parameter int WTE_OFFSET = 100,
    parameter int LOCK_COUNT = 4,
    parameter int BX_W       = 12
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            qie_reset_in,
    input  logic            wte_in,
    input  logic            clear_in,
    output logic            locked,
    output logic [BX_W-1:0] bx_count,
    output logic [15:0]     orbit_count,
    output logic [15:0]     wte_count,
    output logic [BX_W-1:0] wte_phase,
    output logic [7:0]      orbit_err_count,
    output logic [7:0]      wte_err_count
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [BX_W-1:0]   BX_MAX    = '1;
    // bx_count value seen in the cycle of a correctly spaced QIE rise
    localparam logic [BX_W-1:0]   BX_LAST   = BX_W'(ORBIT_LEN - 1);
    localparam logic [BX_W-1:0]   BX_WTE    = BX_W'(WTE_OFFSET);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [7:0]        ERR_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    logic        qie_s;
    logic        qie_s_d;
    logic        wte_s;
    logic        wte_s_d;
    logic        qie_rise;
    logic        wte_rise;

    state_t      state;
    state_t      state_next;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_next;

    logic        period_good;
    logic        orbit_inc;
    logic        orbit_err;
    logic        wte_err;

    // -----------------------------------------------------------------------
    // Input registering and rising-edge detection
    //
    // The first register samples the line, the second holds the previous
    // sample. A rise is therefore visible in the cycle after the line is
    // first sampled high, and every consequence of it lands on the next
    // clock edge. A held level yields a single rise.
    // -----------------------------------------------------------------------
    // NOTE: every register, including the edge-detect stages, is cleared by
    // the asynchronous reset so no stale edge can fire right after release.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            qie_s   <= 1'b0;
            qie_s_d <= 1'b0;
            wte_s   <= 1'b0;
            wte_s_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make qie_s_d take the old qie_s,
            // giving a true one-cycle delay stage.
            qie_s   <= qie_reset_in;
            qie_s_d <= qie_s;
            wte_s   <= wte_in;
            wte_s_d <= wte_s;
        end
    end

    assign qie_rise = qie_s & ~qie_s_d;
    assign wte_rise = wte_s & ~wte_s_d;

    // Measured period at a rise is bx_count + 1, so a good period is the
    // rise arriving while bx_count sits at ORBIT_LEN - 1.
    assign period_good = (bx_count == BX_LAST);

    // -----------------------------------------------------------------------
    // Bunch-crossing counter: restarts on every QIE rise regardless of FSM
    // state, otherwise counts up and sticks at all-ones.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            bx_count <= '0;
        end else if (qie_rise) begin
            bx_count <= '0;
        end else if (bx_count != BX_MAX) begin
            bx_count <= bx_count + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Orbit-lock FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
        end
    end

    // -----------------------------------------------------------------------
    // Orbit-lock FSM: next state and per-cycle event strobes
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_next = state;
        good_next  = good_cnt;
        orbit_inc  = 1'b0;
        orbit_err  = 1'b0;

        case (state)
            ST_SEARCH: begin
                if (qie_rise) begin
                    state_next = ST_ACQUIRE;
                    good_next  = '0;
                end
            end

            ST_ACQUIRE: begin
                if (qie_rise) begin
                    if (period_good) begin
                        good_next = good_cnt + GOOD_ONE;
                        if (good_next == GOOD_LOCK) begin
                            state_next = ST_LOCKED;
                        end
                    end else begin
                        good_next = '0;
                    end
                end else if (bx_count == BX_MAX) begin
                    // No QIE reset for a whole counter range: start over.
                    state_next = ST_SEARCH;
                end
            end

            ST_LOCKED: begin
                if (qie_rise) begin
                    if (period_good) begin
                        orbit_inc = 1'b1;
                    end else begin
                        orbit_err  = 1'b1;
                        state_next = ST_ACQUIRE;
                        good_next  = '0;
                    end
                end else if (bx_count == BX_LAST) begin
                    // The expected reset is absent: the error lands on the
                    // same edge on which bx_count steps to ORBIT_LEN, and the
                    // counter keeps running.
                    orbit_err  = 1'b1;
                    state_next = ST_ACQUIRE;
                    good_next  = '0;
                end
            end

            default: begin
                state_next = ST_SEARCH;
                good_next  = '0;
            end
        endcase
    end

    assign locked = (state == ST_LOCKED);

    // A WTE edge is judged against the pre-update bx_count, so a WTE that
    // coincides with a QIE rise reports the last position of the old orbit.
    assign wte_err = wte_rise && (state == ST_LOCKED) && (bx_count != BX_WTE);

    // -----------------------------------------------------------------------
    // Statistics counters. clear_in takes priority over any increment in the
    // same cycle and leaves the FSM and bx_count untouched.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            orbit_count     <= '0;
            wte_count       <= '0;
            wte_phase       <= '0;
            orbit_err_count <= '0;
            wte_err_count   <= '0;
        end else if (clear_in) begin
            orbit_count     <= '0;
            wte_count       <= '0;
            wte_phase       <= '0;
            orbit_err_count <= '0;
            wte_err_count   <= '0;
        end else begin
            if (orbit_inc) begin
                orbit_count <= orbit_count + 16'd1;
            end

            if (orbit_err && (orbit_err_count != ERR_MAX)) begin
                orbit_err_count <= orbit_err_count + 8'd1;
            end

            if (wte_rise) begin
                wte_count <= wte_count + 16'd1;
                wte_phase <= bx_count;
            end

            if (wte_err && (wte_err_count != ERR_MAX)) begin
                wte_err_count <= wte_err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fast_control_monitor.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fast_control_monitor
//
// Scenario-driven bench for fast_control_monitor. Expected values are pushed
// into exp_q when stimulus is applied and popped when the DUT result is due.
// Inputs change 1 ns after a rising clock edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_fast_control_monitor;

    localparam int ORBIT = 3564;
    localparam int BX_W  = 12;

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic            qie_reset_in;
    logic            wte_in;
    logic            clear_in;
    logic            locked;
    logic [BX_W-1:0] bx_count;
    logic [15:0]     orbit_count;
    logic [15:0]     wte_count;
    logic [BX_W-1:0] wte_phase;
    logic [7:0]      orbit_err_count;
    logic [7:0]      wte_err_count;

    int total = 0;
    int bad   = 0;
    int unsigned exp_q[$];
    int unsigned exp;

    fast_control_monitor #(
        .ORBIT_LEN (ORBIT),
        .WTE_OFFSET(100),
        .LOCK_COUNT(4),
        .BX_W      (BX_W)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .qie_reset_in   (qie_reset_in),
        .wte_in         (wte_in),
        .clear_in       (clear_in),
        .locked         (locked),
        .bx_count       (bx_count),
        .orbit_count    (orbit_count),
        .wte_count      (wte_count),
        .wte_phase      (wte_phase),
        .orbit_err_count(orbit_err_count),
        .wte_err_count  (wte_err_count)
    );

    always #5 clk_in = ~clk_in;

    // Advance n rising edges and settle 1 ns after the last one.
    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk_in);
            #1;
        end
    endtask

    // One-cycle QIE pulse followed by enough idle cycles for a period of gap.
    task automatic qie_pulse(input int gap);
        qie_reset_in = 1'b1;
        tick(1);
        qie_reset_in = 1'b0;
        tick(gap - 1);
    endtask

    task automatic test_reset();
        reset_in     = 1'b1;
        qie_reset_in = 1'b0;
        wte_in       = 1'b0;
        clear_in     = 1'b0;
        exp_q.push_back(0);
        #1;
        exp = exp_q.pop_front(); total++;
        if ({locked, bx_count, orbit_count, wte_count, wte_phase,
             orbit_err_count, wte_err_count} !== 73'(exp)) begin
            bad++;
            $display("FAIL reset_zero: locked=%0d bx=%0d orbit=%0d wte=%0d phase=%0d oerr=%0d werr=%0d, all required 0",
                     locked, bx_count, orbit_count, wte_count, wte_phase, orbit_err_count, wte_err_count);
        end
        tick(3);
        reset_in = 1'b0;
        exp_q.push_back(5);
        tick(5);
        exp = exp_q.pop_front(); total++;
        if (bx_count !== exp[BX_W-1:0]) begin
            bad++; $display("FAIL bx_free_run: got %0d required %0d", bx_count, exp);
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 4; i++) qie_pulse(ORBIT);
        // 5th pulse: lock appears one cycle after its rise
        qie_reset_in = 1'b1;
        exp_q.push_back(0);
        tick(1);
        exp = exp_q.pop_front(); total++;
        if (locked !== exp[0]) begin
            bad++; $display("FAIL lock_early: locked=%0d required %0d", locked, exp[0]);
        end
        qie_reset_in = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(0);
        tick(1);
        exp = exp_q.pop_front(); total++;
        if (locked !== exp[0]) begin
            bad++; $display("FAIL lock_rise: locked=%0d required %0d", locked, exp[0]);
        end
        exp = exp_q.pop_front(); total++;
        if (orbit_count !== exp[15:0]) begin
            bad++; $display("FAIL lock_orbit0: orbit=%0d required %0d", orbit_count, exp);
        end
        tick(ORBIT - 2);
        // 6th pulse: first counted orbit
        qie_reset_in = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(0);
        tick(1);
        qie_reset_in = 1'b0;
        tick(1);
        exp = exp_q.pop_front(); total++;
        if (orbit_count !== exp[15:0]) begin
            bad++; $display("FAIL lock_orbit1: orbit=%0d required %0d", orbit_count, exp);
        end
        exp = exp_q.pop_front(); total++;
        if (orbit_err_count !== exp[7:0]) begin
            bad++; $display("FAIL lock_oerr: oerr=%0d required %0d", orbit_err_count, exp);
        end
        tick(ORBIT - 2);
    endtask

    // One locked orbit with a WTE pulse driven d cycles after the QIE pulse
    // (d = 0 means coincident). The WTE rise sees bx_count = d - 1.
    task automatic wte_orbit(input int d, input int e_phase, input int e_werr,
                             input int e_cnt, input int e_orbit);
        qie_reset_in = 1'b1;
        if (d == 0) wte_in = 1'b1;
        exp_q.push_back(e_phase);
        exp_q.push_back(e_werr);
        exp_q.push_back(e_cnt);
        exp_q.push_back(e_orbit);
        tick(1);
        qie_reset_in = 1'b0;
        wte_in       = 1'b0;
        if (d > 0) begin
            tick(d - 1);
            wte_in = 1'b1;
            tick(1);
            wte_in = 1'b0;
        end
        tick(1);
        exp = exp_q.pop_front(); total++;
        if (wte_phase !== exp[BX_W-1:0]) begin
            bad++; $display("FAIL wte_phase d=%0d: phase=%0d required %0d", d, wte_phase, exp);
        end
        exp = exp_q.pop_front(); total++;
        if (wte_err_count !== exp[7:0]) begin
            bad++; $display("FAIL wte_err d=%0d: werr=%0d required %0d", d, wte_err_count, exp);
        end
        exp = exp_q.pop_front(); total++;
        if (wte_count !== exp[15:0]) begin
            bad++; $display("FAIL wte_count d=%0d: count=%0d required %0d", d, wte_count, exp);
        end
        exp = exp_q.pop_front(); total++;
        if (orbit_count !== exp[15:0]) begin
            bad++; $display("FAIL wte_orbit d=%0d: orbit=%0d required %0d", d, orbit_count, exp);
        end
        tick((d > 0) ? (ORBIT - d - 2) : (ORBIT - 2));
    endtask

    task automatic test_wte();
        wte_orbit(101, 100,  0, 1, 2);
        wte_orbit(101, 100,  0, 2, 3);
        wte_orbit(102, 101,  1, 3, 4);
        wte_orbit(0,   3563, 2, 4, 5);
    endtask

    task automatic test_clear();
        qie_reset_in = 1'b1;
        wte_in       = 1'b1;
        tick(1);
        qie_reset_in = 1'b0;
        wte_in       = 1'b0;
        clear_in     = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(0);
        tick(1);
        clear_in = 1'b0;
        exp = exp_q.pop_front(); total++;
        if ({orbit_count, wte_count, wte_phase, orbit_err_count, wte_err_count} !== 60'(exp)) begin
            bad++;
            $display("FAIL clear_stats: orbit=%0d wte=%0d phase=%0d oerr=%0d werr=%0d, all required 0",
                     orbit_count, wte_count, wte_phase, orbit_err_count, wte_err_count);
        end
        exp = exp_q.pop_front(); total++;
        if (locked !== exp[0]) begin
            bad++; $display("FAIL clear_locked: locked=%0d required %0d", locked, exp[0]);
        end
        exp = exp_q.pop_front(); total++;
        if (bx_count !== exp[BX_W-1:0]) begin
            bad++; $display("FAIL clear_bx: bx=%0d required %0d", bx_count, exp);
        end
        tick(ORBIT - 2);
    endtask

    task automatic test_bad_period();
        qie_pulse(ORBIT - 1);  // good period ends here, next one is short
        qie_reset_in = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(1);
        tick(1);
        qie_reset_in = 1'b0;
        tick(1);
        exp = exp_q.pop_front(); total++;
        if (orbit_err_count !== exp[7:0]) begin
            bad++; $display("FAIL bad_oerr: oerr=%0d required %0d", orbit_err_count, exp);
        end
        exp = exp_q.pop_front(); total++;
        if (locked !== exp[0]) begin
            bad++; $display("FAIL bad_unlock: locked=%0d required %0d", locked, exp[0]);
        end
        exp = exp_q.pop_front(); total++;
        if (orbit_count !== exp[15:0]) begin
            bad++; $display("FAIL bad_orbit: orbit=%0d required %0d", orbit_count, exp);
        end
        tick(ORBIT - 2);
        qie_pulse(ORBIT);
        qie_pulse(ORBIT);
        // third good period: still acquiring
        qie_reset_in = 1'b1;
        exp_q.push_back(0);
        tick(1);
        qie_reset_in = 1'b0;
        tick(1);
        exp = exp_q.pop_front(); total++;
        if (locked !== exp[0]) begin
            bad++; $display("FAIL relock_early: locked=%0d required %0d", locked, exp[0]);
        end
        tick(ORBIT - 2);
        // fourth good period: locked again, orbit count unchanged
        qie_reset_in = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(1);
        tick(1);
        qie_reset_in = 1'b0;
        tick(1);
        exp = exp_q.pop_front(); total++;
        if (locked !== exp[0]) begin
            bad++; $display("FAIL relock: locked=%0d required %0d", locked, exp[0]);
        end
        exp = exp_q.pop_front(); total++;
        if (orbit_count !== exp[15:0]) begin
            bad++; $display("FAIL relock_orbit: orbit=%0d required %0d", orbit_count, exp);
        end
        tick(ORBIT - 2);
    endtask

    task automatic test_reset_mid_lock();
        tick(1000);
        reset_in = 1'b1;
        exp_q.push_back(0);
        #2;
        exp = exp_q.pop_front(); total++;
        if ({locked, bx_count, orbit_count, wte_count, wte_phase,
             orbit_err_count, wte_err_count} !== 73'(exp)) begin
            bad++;
            $display("FAIL reset_async: locked=%0d bx=%0d orbit=%0d wte=%0d phase=%0d oerr=%0d werr=%0d, all required 0",
                     locked, bx_count, orbit_count, wte_count, wte_phase, orbit_err_count, wte_err_count);
        end
        #1;
        reset_in = 1'b0;
        wte_in   = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(1);
        exp_q.push_back(0);
        tick(50);
        wte_in = 1'b0;
        tick(2);
        exp = exp_q.pop_front(); total++;
        if (wte_count !== exp[15:0]) begin
            bad++; $display("FAIL held_wte_count: count=%0d required %0d", wte_count, exp);
        end
        exp = exp_q.pop_front(); total++;
        if (wte_phase !== exp[BX_W-1:0]) begin
            bad++; $display("FAIL held_wte_phase: phase=%0d required %0d", wte_phase, exp);
        end
        exp = exp_q.pop_front(); total++;
        if ({locked, wte_err_count} !== 9'(exp)) begin
            bad++; $display("FAIL held_wte_unlocked: locked=%0d werr=%0d required 0 0", locked, wte_err_count);
        end
    endtask

    task automatic test_missing_reset();
        for (int i = 0; i < 4; i++) qie_pulse(ORBIT);
        qie_reset_in = 1'b1;
        exp_q.push_back(0);
        tick(1);
        qie_reset_in = 1'b0;
        exp = exp_q.pop_front(); total++;
        if (locked !== exp[0]) begin
            bad++; $display("FAIL reacq_early: locked=%0d required %0d", locked, exp[0]);
        end
        exp_q.push_back(1);
        tick(1);
        exp = exp_q.pop_front(); total++;
        if (locked !== exp[0]) begin
            bad++; $display("FAIL reacq_lock: locked=%0d required %0d", locked, exp[0]);
        end
        tick(ORBIT - 2);
        // pulses stop here
        exp_q.push_back(1);
        exp_q.push_back(0);
        tick(1);
        exp = exp_q.pop_front(); total++;
        if (locked !== exp[0]) begin
            bad++; $display("FAIL miss_last_bx_locked: locked=%0d required %0d", locked, exp[0]);
        end
        exp = exp_q.pop_front(); total++;
        if (orbit_err_count !== exp[7:0]) begin
            bad++; $display("FAIL miss_last_bx_oerr: oerr=%0d required %0d", orbit_err_count, exp);
        end
        exp_q.push_back(ORBIT);
        exp_q.push_back(1);
        exp_q.push_back(0);
        tick(1);
        exp = exp_q.pop_front(); total++;
        if (bx_count !== exp[BX_W-1:0]) begin
            bad++; $display("FAIL miss_bx: bx=%0d required %0d", bx_count, exp);
        end
        exp = exp_q.pop_front(); total++;
        if (orbit_err_count !== exp[7:0]) begin
            bad++; $display("FAIL miss_oerr: oerr=%0d required %0d", orbit_err_count, exp);
        end
        exp = exp_q.pop_front(); total++;
        if (locked !== exp[0]) begin
            bad++; $display("FAIL miss_unlock: locked=%0d required %0d", locked, exp[0]);
        end
        exp_q.push_back(4095);
        tick(4095 - ORBIT);
        exp = exp_q.pop_front(); total++;
        if (bx_count !== exp[BX_W-1:0]) begin
            bad++; $display("FAIL bx_reach_max: bx=%0d required %0d", bx_count, exp);
        end
        exp_q.push_back(4095);
        exp_q.push_back(1);
        tick(5);
        exp = exp_q.pop_front(); total++;
        if (bx_count !== exp[BX_W-1:0]) begin
            bad++; $display("FAIL bx_saturate: bx=%0d required %0d", bx_count, exp);
        end
        exp = exp_q.pop_front(); total++;
        if (orbit_err_count !== exp[7:0]) begin
            bad++; $display("FAIL sat_oerr: oerr=%0d required %0d", orbit_err_count, exp);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wte();
        test_clear();
        test_bad_period();
        test_reset_mid_lock();
        test_missing_reset();
        if (exp_q.size() != 0) begin
            bad++; total++;
            $display("FAIL scoreboard_leftover: %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
